// File: rtl/fb_text_writer.sv
// Text console renderer: draws 8x8 glyphs for a 16x8 character grid into a 1024-byte frame buffer.
// Handles newline, backspace, form feed, cursor wrap and row/screen clear.
module fb_text_writer #(
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter int unsigned INVERT         = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_Char,
    input  logic       i_Char_DV,
    output logic       o_Ready,
    output logic [9:0] o_Font_Addr,
    input  logic [7:0] i_Font_Byte,
    output logic [9:0] o_FB_Addr,
    output logic [7:0] o_FB_Data,
    output logic       o_FB_WE,
    output logic [3:0] o_Cursor_Col,
    output logic [2:0] o_Cursor_Row
);

    localparam int unsigned CNT_W = 11;
    localparam logic [7:0]  BLANK_BYTE = (INVERT != 0) ? 8'hFF : 8'h00;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_GLYPH  = 3'd2;
    localparam logic [2:0] S_BLANK  = 3'd3;
    localparam logic [2:0] S_ROWCLR = 3'd4;
    localparam logic [2:0] S_SCRCLR = 3'd5;

    logic [2:0]       r_State, w_State_Nxt;
    logic [CNT_W-1:0] r_Cnt, w_Cnt_Nxt;
    logic [6:0]       r_Glyph, w_Glyph_Nxt;
    logic [3:0]       r_Col, w_Col_Nxt;
    logic [2:0]       r_Row, w_Row_Nxt;
    logic             r_Ready, w_Ready_Nxt;
    logic [9:0]       r_Font_Addr, w_Font_Addr_Nxt;
    logic             r_FB_WE, w_FB_WE_Nxt;
    logic [9:0]       r_FB_Addr, w_FB_Addr_Nxt;
    logic [7:0]       r_FB_Data, w_FB_Data_Nxt;
    logic             w_Accept;
    logic [2:0]       w_K;
    logic [7:0]       w_Glyph_Byte;

    assign w_Accept     = r_Ready & i_Char_DV;
    // Font byte returning this cycle belongs to the address issued two edges ago
    assign w_K          = r_Cnt[2:0] - 3'd1;
    assign w_Glyph_Byte = (INVERT != 0) ? ~i_Font_Byte : i_Font_Byte;

    always_comb begin
        w_State_Nxt     = r_State;
        w_Cnt_Nxt       = r_Cnt;
        w_Glyph_Nxt     = r_Glyph;
        w_Col_Nxt       = r_Col;
        w_Row_Nxt       = r_Row;
        w_Font_Addr_Nxt = r_Font_Addr;
        w_FB_WE_Nxt     = 1'b0;
        w_FB_Addr_Nxt   = r_FB_Addr;
        w_FB_Data_Nxt   = r_FB_Data;

        case (r_State)
            S_INIT: begin
                w_Cnt_Nxt   = CNT_W'(0);
                w_State_Nxt = (CLEAR_ON_RESET != 0) ? S_SCRCLR : S_IDLE;
            end
            S_IDLE: begin
                w_Cnt_Nxt = CNT_W'(0);
                if (w_Accept) begin
                    if ((i_Char >= 8'h20) && (i_Char <= 8'h7E)) begin
                        w_Glyph_Nxt     = i_Char[6:0];
                        w_Font_Addr_Nxt = {i_Char[6:0], 3'd0};
                        w_State_Nxt     = S_GLYPH;
                    end else if (i_Char[7]) begin
                        w_Glyph_Nxt     = 7'h3F;
                        w_Font_Addr_Nxt = {7'h3F, 3'd0};
                        w_State_Nxt     = S_GLYPH;
                    end else if ((i_Char == 8'h0A) || (i_Char == 8'h0D)) begin
                        w_Col_Nxt   = 4'd0;
                        w_Row_Nxt   = r_Row + 3'd1;
                        w_State_Nxt = S_ROWCLR;
                    end else if (i_Char == 8'h08) begin
                        if (r_Col != 4'd0) begin
                            w_Col_Nxt   = r_Col - 4'd1;
                            w_State_Nxt = S_BLANK;
                        end else if (r_Row != 3'd0) begin
                            w_Col_Nxt   = 4'd15;
                            w_Row_Nxt   = r_Row - 3'd1;
                            w_State_Nxt = S_BLANK;
                        end
                    end else if (i_Char == 8'h0C) begin
                        w_State_Nxt = S_SCRCLR;
                    end
                end
            end
            S_GLYPH: begin
                w_Cnt_Nxt = r_Cnt + CNT_W'(1);
                if ((r_Cnt >= CNT_W'(1)) && (r_Cnt <= CNT_W'(8))) begin
                    w_FB_WE_Nxt   = 1'b1;
                    w_FB_Addr_Nxt = {r_Row, r_Col, w_K};
                    w_FB_Data_Nxt = w_Glyph_Byte;
                end
                if (r_Cnt <= CNT_W'(6)) begin
                    w_Font_Addr_Nxt = {r_Glyph, r_Cnt[2:0] + 3'd1};
                end
                if (r_Cnt == CNT_W'(9)) begin
                    w_Cnt_Nxt = CNT_W'(0);
                    if (r_Col == 4'd15) begin
                        w_Col_Nxt   = 4'd0;
                        w_Row_Nxt   = r_Row + 3'd1;
                        w_State_Nxt = S_ROWCLR;
                    end else begin
                        w_Col_Nxt   = r_Col + 4'd1;
                        w_State_Nxt = S_IDLE;
                    end
                end
            end
            S_BLANK: begin
                w_Cnt_Nxt = r_Cnt + CNT_W'(1);
                if (r_Cnt < CNT_W'(8)) begin
                    w_FB_WE_Nxt   = 1'b1;
                    w_FB_Addr_Nxt = {r_Row, r_Col, r_Cnt[2:0]};
                    w_FB_Data_Nxt = BLANK_BYTE;
                end else begin
                    w_Cnt_Nxt   = CNT_W'(0);
                    w_State_Nxt = S_IDLE;
                end
            end
            S_ROWCLR: begin
                w_Cnt_Nxt = r_Cnt + CNT_W'(1);
                if (r_Cnt < CNT_W'(128)) begin
                    w_FB_WE_Nxt   = 1'b1;
                    w_FB_Addr_Nxt = {r_Row, r_Cnt[6:0]};
                    w_FB_Data_Nxt = BLANK_BYTE;
                end else begin
                    w_Cnt_Nxt   = CNT_W'(0);
                    w_State_Nxt = S_IDLE;
                end
            end
            S_SCRCLR: begin
                w_Cnt_Nxt = r_Cnt + CNT_W'(1);
                if (r_Cnt < CNT_W'(1024)) begin
                    w_FB_WE_Nxt   = 1'b1;
                    w_FB_Addr_Nxt = r_Cnt[9:0];
                    w_FB_Data_Nxt = BLANK_BYTE;
                end else begin
                    w_Cnt_Nxt   = CNT_W'(0);
                    w_Col_Nxt   = 4'd0;
                    w_Row_Nxt   = 3'd0;
                    w_State_Nxt = S_IDLE;
                end
            end
            default: begin
                w_Cnt_Nxt   = CNT_W'(0);
                w_State_Nxt = S_IDLE;
            end
        endcase

        // An accepted code always costs at least one not-ready cycle, even when ignored
        w_Ready_Nxt = (w_State_Nxt == S_IDLE) && !w_Accept;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State     <= S_INIT;
            r_Cnt       <= CNT_W'(0);
            r_Glyph     <= 7'd0;
            r_Col       <= 4'd0;
            r_Row       <= 3'd0;
            r_Ready     <= 1'b0;
            r_Font_Addr <= 10'd0;
            r_FB_WE     <= 1'b0;
            r_FB_Addr   <= 10'd0;
            r_FB_Data   <= 8'd0;
        end else begin
            r_State     <= w_State_Nxt;
            r_Cnt       <= w_Cnt_Nxt;
            r_Glyph     <= w_Glyph_Nxt;
            r_Col       <= w_Col_Nxt;
            r_Row       <= w_Row_Nxt;
            r_Ready     <= w_Ready_Nxt;
            r_Font_Addr <= w_Font_Addr_Nxt;
            r_FB_WE     <= w_FB_WE_Nxt;
            r_FB_Addr   <= w_FB_Addr_Nxt;
            r_FB_Data   <= w_FB_Data_Nxt;
        end
    end

    assign o_Ready      = r_Ready;
    assign o_Font_Addr  = r_Font_Addr;
    assign o_FB_WE      = r_FB_WE;
    assign o_FB_Addr    = r_FB_Addr;
    assign o_FB_Data    = r_FB_Data;
    assign o_Cursor_Col = r_Col;
    assign o_Cursor_Row = r_Row;

endmodule

// File: tb/tb_fb_text_writer.sv
// Directed bench for fb_text_writer: dut0 is the normal build, dut1 the inverted build.
// The font ROM model returns the low 8 address bits one cycle after the address.
module tb_fb_text_writer;

    logic       clk = 1'b0;
    logic       rst_n     [2];
    logic [7:0] ch        [2];
    logic       dv        [2];
    logic       rdy       [2];
    logic [9:0] font_addr [2];
    logic [7:0] font_byte [2];
    logic [9:0] fb_addr   [2];
    logic [7:0] fb_data   [2];
    logic       we        [2];
    logic [3:0] col       [2];
    logic [2:0] row       [2];

    logic [9:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int first_n, last_n, ready_n;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_text_writer #(.CLEAR_ON_RESET(1), .INVERT(0)) u_dut0 (
        .i_Clk(clk), .i_Rst_L(rst_n[0]), .i_Char(ch[0]), .i_Char_DV(dv[0]), .o_Ready(rdy[0]),
        .o_Font_Addr(font_addr[0]), .i_Font_Byte(font_byte[0]), .o_FB_Addr(fb_addr[0]),
        .o_FB_Data(fb_data[0]), .o_FB_WE(we[0]), .o_Cursor_Col(col[0]), .o_Cursor_Row(row[0])
    );

    fb_text_writer #(.CLEAR_ON_RESET(1), .INVERT(1)) u_dut1 (
        .i_Clk(clk), .i_Rst_L(rst_n[1]), .i_Char(ch[1]), .i_Char_DV(dv[1]), .o_Ready(rdy[1]),
        .o_Font_Addr(font_addr[1]), .i_Font_Byte(font_byte[1]), .o_FB_Addr(fb_addr[1]),
        .o_FB_Data(fb_data[1]), .o_FB_WE(we[1]), .o_Cursor_Col(col[1]), .o_Cursor_Row(row[1])
    );

    always @(posedge clk) begin
        font_byte[0] <= font_addr[0][7:0];
        font_byte[1] <= font_addr[1][7:0];
    end

    // Mismatches between captured writes [qoff..] and addr base+i, data d0+i*dstep
    function automatic int seq_bad(int qoff, int base, int n, int d0, int dstep);
        int b = 0;
        for (int i = 0; i < n; i++) begin
            if (qoff + i >= wr_addr.size()) b++;
            else if (wr_addr[qoff+i] !== 10'(base + i) || wr_data[qoff+i] !== 8'(d0 + i * dstep)) b++;
        end
        return b;
    endfunction

    // Record writes each cycle (n = edges since accept) until o_Ready or the budget runs out
    task automatic collect(input int sel, input int maxc);
        wr_addr.delete();
        wr_data.delete();
        first_n = -1;
        last_n  = -1;
        ready_n = -1;
        for (int n = 0; n <= maxc; n++) begin
            if (n > 0) @(negedge clk);
            if (we[sel]) begin
                wr_addr.push_back(fb_addr[sel]);
                wr_data.push_back(fb_data[sel]);
                if (first_n < 0) first_n = n;
                last_n = n;
            end
            if (rdy[sel]) begin
                ready_n = n;
                break;
            end
        end
    endtask

    task automatic send(input int sel, input logic [7:0] c);
        int t = 0;
        while (!rdy[sel] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (rdy[sel] !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready dut%0d: ready=%b want 1 before char %h", sel, rdy[sel], c);
        end
        ch[sel] = c;
        dv[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv[sel] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({rdy[0], we[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ctrl: ready/we=%b want 00", {rdy[0], we[0]});
        end
        n_vec++;
        if ({fb_addr[0], fb_data[0], font_addr[0], col[0], row[0]} !== '0) begin
            n_err++;
            $display("FAIL reset_data: addr=%0d data=%h font=%0d col=%0d row=%0d want all 0",
                     fb_addr[0], fb_data[0], font_addr[0], col[0], row[0]);
        end
        rst_n[0] = 1'b1;
        collect(0, 1200);
        n_vec++;
        if (wr_addr.size() != 1024 || seq_bad(0, 0, 1024, 0, 0) != 0) begin
            n_err++;
            $display("FAIL reset_clear: writes=%0d bad=%0d want 1024 bad=0", wr_addr.size(), seq_bad(0, 0, 1024, 0, 0));
        end
        n_vec++;
        if (ready_n < 0 || col[0] !== 4'd0 || row[0] !== 3'd0) begin
            n_err++;
            $display("FAIL reset_done: ready_n=%0d col=%0d row=%0d want ready, 0, 0", ready_n, col[0], row[0]);
        end
    endtask

    task automatic test_glyph;
        send(0, 8'h41);
        collect(0, 50);
        n_vec++;
        if (wr_addr.size() != 8 || seq_bad(0, 0, 8, 8'h08, 1) != 0) begin
            n_err++;
            $display("FAIL glyph_A_data: writes=%0d bad=%0d want 8 bad=0", wr_addr.size(), seq_bad(0, 0, 8, 8'h08, 1));
        end
        n_vec++;
        if (first_n != 2 || last_n != 9 || ready_n != 10) begin
            n_err++;
            $display("FAIL glyph_A_timing: first=%0d last=%0d ready=%0d want 2 9 10", first_n, last_n, ready_n);
        end
        n_vec++;
        if (row[0] !== 3'd0 || col[0] !== 4'd1) begin
            n_err++;
            $display("FAIL glyph_A_cursor: row=%0d col=%0d want 0 1", row[0], col[0]);
        end
    endtask

    task automatic test_newline;
        send(0, 8'h0D);
        collect(0, 300);
        n_vec++;
        if (wr_addr.size() != 128 || seq_bad(0, 128, 128, 0, 0) != 0 || ready_n != 129
            || row[0] !== 3'd1 || col[0] !== 4'd0) begin
            n_err++;
            $display("FAIL cr_row1: writes=%0d ready=%0d row=%0d col=%0d want 128 129 1 0",
                     wr_addr.size(), ready_n, row[0], col[0]);
        end
        send(0, 8'h0A);
        collect(0, 300);
        n_vec++;
        if (wr_addr.size() != 128 || seq_bad(0, 256, 128, 0, 0) != 0 || row[0] !== 3'd2 || col[0] !== 4'd0) begin
            n_err++;
            $display("FAIL lf_row2: writes=%0d row=%0d col=%0d want 128 2 0", wr_addr.size(), row[0], col[0]);
        end
    endtask

    task automatic test_row_fill;
        for (int i = 0; i < 16; i++) begin
            send(0, (i == 15) ? 8'hC1 : 8'h42);
            collect(0, 300);
            if (i == 0) begin
                n_vec++;
                if (wr_addr.size() != 8 || seq_bad(0, 256, 8, 8'h10, 1) != 0 || ready_n != 10) begin
                    n_err++;
                    $display("FAIL row2_first: writes=%0d ready=%0d want 8 at 256.. ready 10", wr_addr.size(), ready_n);
                end
            end
            if (i == 15) begin
                n_vec++;
                if (wr_addr.size() != 136 || seq_bad(0, 376, 8, 8'hF8, 1) != 0 || seq_bad(8, 384, 128, 0, 0) != 0) begin
                    n_err++;
                    $display("FAIL row2_last_wrap: writes=%0d glyph_bad=%0d clr_bad=%0d want 136 0 0",
                             wr_addr.size(), seq_bad(0, 376, 8, 8'hF8, 1), seq_bad(8, 384, 128, 0, 0));
                end
                n_vec++;
                if (first_n != 2 || ready_n != 139 || row[0] !== 3'd3 || col[0] !== 4'd0) begin
                    n_err++;
                    $display("FAIL row2_wrap_end: first=%0d ready=%0d row=%0d col=%0d want 2 139 3 0",
                             first_n, ready_n, row[0], col[0]);
                end
            end
        end
    endtask

    task automatic test_backspace;
        send(0, 8'h08);
        collect(0, 50);
        n_vec++;
        if (wr_addr.size() != 8 || seq_bad(0, 376, 8, 0, 0) != 0 || ready_n != 9 || row[0] !== 3'd2 || col[0] !== 4'd15) begin
            n_err++;
            $display("FAIL bs_wrap: writes=%0d ready=%0d row=%0d col=%0d want 8 9 2 15",
                     wr_addr.size(), ready_n, row[0], col[0]);
        end
        send(0, 8'h0C);
        collect(0, 1200);
        n_vec++;
        if (wr_addr.size() != 1024 || seq_bad(0, 0, 1024, 0, 0) != 0 || ready_n != 1025 || row[0] !== 3'd0 || col[0] !== 4'd0) begin
            n_err++;
            $display("FAIL formfeed: writes=%0d ready=%0d row=%0d col=%0d want 1024 1025 0 0",
                     wr_addr.size(), ready_n, row[0], col[0]);
        end
        send(0, 8'h08);
        collect(0, 50);
        n_vec++;
        if (wr_addr.size() != 0 || ready_n != 1 || row[0] !== 3'd0 || col[0] !== 4'd0) begin
            n_err++;
            $display("FAIL bs_origin: writes=%0d ready=%0d row=%0d col=%0d want 0 1 0 0",
                     wr_addr.size(), ready_n, row[0], col[0]);
        end
    endtask

    task automatic test_cr_wrap;
        logic [7:0] codes [5];
        codes = '{8'h07, 8'h7F, 8'h00, 8'h1B, 8'h09};
        for (int i = 0; i < 7; i++) begin
            send(0, 8'h0A);
            collect(0, 300);
        end
        n_vec++;
        if (row[0] !== 3'd7 || col[0] !== 4'd0) begin
            n_err++;
            $display("FAIL lf_to_row7: row=%0d col=%0d want 7 0", row[0], col[0]);
        end
        send(0, 8'h0D);
        collect(0, 300);
        n_vec++;
        if (wr_addr.size() != 128 || seq_bad(0, 0, 128, 0, 0) != 0 || row[0] !== 3'd0 || col[0] !== 4'd0) begin
            n_err++;
            $display("FAIL cr_wrap: writes=%0d row=%0d col=%0d want 128 at 0.., 0 0", wr_addr.size(), row[0], col[0]);
        end
        for (int i = 0; i < 5; i++) begin
            send(0, codes[i]);
            collect(0, 50);
            n_vec++;
            if (wr_addr.size() != 0 || ready_n != 1 || row[0] !== 3'd0 || col[0] !== 4'd0) begin
                n_err++;
                $display("FAIL ignore_%h: writes=%0d ready=%0d row=%0d col=%0d want 0 1 0 0",
                         codes[i], wr_addr.size(), ready_n, row[0], col[0]);
            end
        end
    endtask

    task automatic test_invert;
        rst_n[1] = 1'b1;
        collect(1, 1200);
        n_vec++;
        if (wr_addr.size() != 1024 || seq_bad(0, 0, 1024, 8'hFF, 0) != 0) begin
            n_err++;
            $display("FAIL inv_clear: writes=%0d bad=%0d want 1024 of FF", wr_addr.size(), seq_bad(0, 0, 1024, 8'hFF, 0));
        end
        send(1, 8'h27);
        collect(1, 50);
        n_vec++;
        if (wr_addr.size() != 8 || seq_bad(0, 0, 8, 8'hC7, -1) != 0 || ready_n != 10) begin
            n_err++;
            $display("FAIL inv_glyph: writes=%0d ready=%0d want 8 data C7..C0 ready 10", wr_addr.size(), ready_n);
        end
        n_vec++;
        if (wr_data.size() < 5 || wr_data[4] !== 8'hC3) begin
            n_err++;
            $display("FAIL inv_3c: data=%h want C3", (wr_data.size() < 5) ? 8'h00 : wr_data[4]);
        end
    endtask

    task automatic test_busy_reset;
        int bad = 0;
        int cnt = 0;
        send(1, 8'h0C);
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (we[1]) begin
                if (fb_addr[1] !== 10'(cnt) || fb_data[1] !== 8'hFF) bad++;
                cnt++;
            end
            ch[1] = 8'h41;
            dv[1] = (n % 2 == 0);
        end
        dv[1] = 1'b0;
        n_vec++;
        if (cnt != 39 || bad != 0) begin
            n_err++;
            $display("FAIL busy_dv: writes=%0d bad=%0d want 39 0", cnt, bad);
        end
        #2 rst_n[1] = 1'b0;
        #1;
        n_vec++;
        if (we[1] !== 1'b0 || rdy[1] !== 1'b0 || fb_addr[1] !== 10'd0) begin
            n_err++;
            $display("FAIL midclr_reset: we=%b ready=%b addr=%0d want 0 0 0", we[1], rdy[1], fb_addr[1]);
        end
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (we[1]) cnt++;
        end
        n_vec++;
        if (cnt != 0) begin
            n_err++;
            $display("FAIL reset_hold_we: writes=%0d want 0", cnt);
        end
    endtask

    initial begin
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        ch[0] = 8'h00;
        ch[1] = 8'h00;
        dv[0] = 1'b0;
        dv[1] = 1'b0;
        test_reset();
        test_glyph();
        test_newline();
        test_row_fill();
        test_backspace();
        test_cr_wrap();
        test_invert();
        test_busy_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
